// File: rtl/flowkey_extract.sv
// flowkey_extract: captures the 14-byte Ethernet header from the RX FIFO
// stream, issues one flow-key lookup per frame and returns the result.
//
// Ports:
//   sys_clk, sys_rst_n       clock, async active-low reset
//   rx_dout[8:0], rx_empty   FIFO byte stream (bit8 = in-frame)
//   rx_rd_en                 registered FIFO read enable
//   of_lookup_req/data       lookup request pulse and 116-bit key
//   of_lookup_ack/err/port   lookup response
//   res_valid/err/port       result pulse to fabric control
//   pkt/drop/runt/tmo_cnt    saturating statistics
module flowkey_extract #(
  parameter logic [3:0] PORT_NUM = 4'h0,
  parameter logic [7:0] TIMEOUT  = 8'd16,
  parameter int         CNT_W    = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [8:0]       rx_dout,
  input  logic             rx_empty,
  output logic             rx_rd_en,
  output logic             of_lookup_req,
  output logic [115:0]     of_lookup_data,
  input  logic             of_lookup_ack,
  input  logic             of_lookup_err,
  input  logic [3:0]       of_lookup_fwd_port,
  output logic             res_valid,
  output logic             res_err,
  output logic [3:0]       res_port,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] runt_cnt,
  output logic [CNT_W-1:0] tmo_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [CNT_W-1:0] ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + ONE;
  endfunction

  logic             r_rd_en;
  logic [3:0]       r_bcnt;
  // bytes 0..12 of the header; byte 13 joins straight from rx_dout
  logic [103:0]     r_hdr;
  logic [1:0]       r_state;
  logic [7:0]       r_timer;
  logic             r_req;
  logic [115:0]     r_data;
  logic             r_res_valid;
  logic             r_res_err;
  logic [3:0]       r_res_port;
  logic [CNT_W-1:0] r_pkt;
  logic [CNT_W-1:0] r_drop;
  logic [CNT_W-1:0] r_runt;
  logic [CNT_W-1:0] r_tmo;

  logic         w_acc;
  logic         w_eof;
  logic         w_key_done;
  logic         w_runt;
  logic         w_issue;
  logic         w_drop;
  logic         w_tmo;
  logic [115:0] w_key;

  assign w_acc      = r_rd_en & rx_dout[8];
  assign w_eof      = r_rd_en & ~rx_dout[8];
  assign w_key_done = w_acc & (r_bcnt == 4'd13);
  assign w_runt     = w_eof & (r_bcnt != 4'd0)
                    & (r_bcnt < 4'd14);
  assign w_issue    = w_key_done & (r_state == S_IDLE);
  assign w_drop     = w_key_done & (r_state != S_IDLE);
  // ack has priority over the timeout in the same cycle
  assign w_tmo      = (r_state == S_WAIT) & ~of_lookup_ack
                    & (r_timer == TIMEOUT);
  assign w_key      = {PORT_NUM, r_hdr, rx_dout[7:0]};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rd_en <= 1'b0;
    end else begin
      r_rd_en <= ~rx_empty;
    end
  end

  // byte counter saturates at 14 so long frames cannot re-trigger
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bcnt <= 4'd0;
      r_hdr  <= '0;
    end else begin
      if (w_eof) begin
        r_bcnt <= 4'd0;
      end else if (w_acc && r_bcnt != 4'd14) begin
        r_bcnt <= r_bcnt + 4'd1;
      end
      if (w_acc && r_bcnt < 4'd13) begin
        r_hdr <= {r_hdr[95:0], rx_dout[7:0]};
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= 8'd0;
      r_req       <= 1'b0;
      r_data      <= '0;
      r_res_valid <= 1'b0;
      r_res_err   <= 1'b0;
      r_res_port  <= 4'd0;
    end else begin
      r_req       <= 1'b0;
      r_res_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_key_done) begin
            r_data  <= w_key;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_timer <= 8'd1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (of_lookup_ack) begin
            r_res_valid <= 1'b1;
            r_res_err   <= of_lookup_err;
            r_res_port  <= of_lookup_err ?
                           4'd0 : of_lookup_fwd_port;
            r_state     <= S_IDLE;
          end else if (r_timer == TIMEOUT) begin
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b1;
            r_res_port  <= 4'd0;
            r_state     <= S_IDLE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pkt  <= '0;
      r_drop <= '0;
      r_runt <= '0;
      r_tmo  <= '0;
    end else begin
      if (w_issue) r_pkt  <= sat_inc(r_pkt);
      if (w_drop)  r_drop <= sat_inc(r_drop);
      if (w_runt)  r_runt <= sat_inc(r_runt);
      if (w_tmo)   r_tmo  <= sat_inc(r_tmo);
    end
  end

  assign rx_rd_en       = r_rd_en;
  assign of_lookup_req  = r_req;
  assign of_lookup_data = r_data;
  assign res_valid      = r_res_valid;
  assign res_err        = r_res_err;
  assign res_port       = r_res_port;
  assign pkt_cnt        = r_pkt;
  assign drop_cnt       = r_drop;
  assign runt_cnt       = r_runt;
  assign tmo_cnt        = r_tmo;

endmodule

// File: tb/tb_flowkey_extract.sv
// tb_flowkey_extract: directed and random frames against a
// deadline-based model of the header parser and lookup handshake.
module tb_flowkey_extract;

  localparam logic [3:0] PN  = 4'h2;
  localparam int         TMO = 16;

  logic         sys_clk;
  logic         sys_rst_n;
  logic [8:0]   rx_dout;
  logic         rx_empty;
  logic         rx_rd_en;
  logic         of_lookup_req;
  logic [115:0] of_lookup_data;
  logic         of_lookup_ack;
  logic         of_lookup_err;
  logic [3:0]   of_lookup_fwd_port;
  logic         res_valid;
  logic         res_err;
  logic [3:0]   res_port;
  logic [15:0]  pkt_cnt;
  logic [15:0]  drop_cnt;
  logic [15:0]  runt_cnt;
  logic [15:0]  tmo_cnt;

  flowkey_extract #(
    .PORT_NUM (PN),
    .TIMEOUT  (8'd16),
    .CNT_W    (16)
  ) dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .rx_dout            (rx_dout),
    .rx_empty           (rx_empty),
    .rx_rd_en           (rx_rd_en),
    .of_lookup_req      (of_lookup_req),
    .of_lookup_data     (of_lookup_data),
    .of_lookup_ack      (of_lookup_ack),
    .of_lookup_err      (of_lookup_err),
    .of_lookup_fwd_port (of_lookup_fwd_port),
    .res_valid          (res_valid),
    .res_err            (res_err),
    .res_port           (res_port),
    .pkt_cnt            (pkt_cnt),
    .drop_cnt           (drop_cnt),
    .runt_cnt           (runt_cnt),
    .tmo_cnt            (tmo_cnt)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  typedef struct {
    string        nm;
    logic [115:0] a;
    logic [115:0] e;
  } lit_t;
  lit_t lq[$];
  int   lq_rd = 0;

  function automatic int sat(int v);
    return (v >= 65535) ? v : v + 1;
  endfunction

  function automatic void chk(string nm,
                              logic [115:0] a,
                              logic [115:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h @cycle %0d",
               nm, a, e, cyc);
    end
  endfunction

  task automatic lit(string nm, logic [115:0] a,
                     logic [115:0] e);
    lq.push_back('{nm, a, e});
  endtask

  // ---------------- reference model ----------------
  logic         m_rden;
  int           m_len;
  logic [111:0] m_hdr;
  logic         m_out;
  int           m_c;
  logic         e_req, e_vld, e_err;
  logic [3:0]   e_port;
  logic [115:0] e_key;
  int           e_pkt, e_drop, e_runt, e_tmo;

  always @(posedge sys_clk or negedge sys_rst_n) begin : model
    int n, len, c, pkt, drop, runt, tmo;
    logic out, busy, acc, eof, kd, vld, err, req;
    logic [3:0] port;
    logic [111:0] hdr;
    logic [115:0] key;
    if (!sys_rst_n) begin
      m_rden <= 0; m_len <= 0; m_hdr <= '0;
      m_out <= 0; m_c <= 0;
      e_req <= 0; e_vld <= 0; e_err <= 0;
      e_port <= 0; e_key <= '0;
      e_pkt <= 0; e_drop <= 0; e_runt <= 0; e_tmo <= 0;
    end else begin
      n = cyc; len = m_len; hdr = m_hdr;
      out = m_out; busy = m_out; c = m_c;
      vld = 0; req = 0; err = e_err; port = e_port;
      key = e_key; pkt = e_pkt; drop = e_drop;
      runt = e_runt; tmo = e_tmo;
      acc = m_rden && rx_dout[8];
      eof = m_rden && !rx_dout[8];
      kd = 0;
      if (eof) begin
        if (len > 0 && len < 14) runt = sat(runt);
        len = 0;
      end else if (acc && len < 14) begin
        hdr[111-8*len -: 8] = rx_dout[7:0];
        kd = (len == 13);
        len++;
      end
      // lookup window: WAIT cycles are c+2 .. c+1+TMO
      if (out) begin
        if (n >= c + 2 && of_lookup_ack) begin
          vld = 1; err = of_lookup_err;
          port = err ? 4'h0 : of_lookup_fwd_port;
          out = 0;
        end else if (n == c + 1 + TMO) begin
          vld = 1; err = 1; port = 0;
          tmo = sat(tmo); out = 0;
        end
      end
      if (kd) begin
        if (busy) drop = sat(drop);
        else begin
          out = 1; c = n; req = 1;
          key = {PN, hdr}; pkt = sat(pkt);
        end
      end
      m_rden <= !rx_empty; m_len <= len; m_hdr <= hdr;
      m_out <= out; m_c <= c;
      e_req <= req; e_vld <= vld; e_err <= err;
      e_port <= port; e_key <= key;
      e_pkt <= pkt; e_drop <= drop;
      e_runt <= runt; e_tmo <= tmo;
    end
  end

  // ---------------- compare ----------------
  always @(negedge sys_clk) begin
    if (chk_on) begin
      chk("rd_en", rx_rd_en, m_rden);
      chk("req", of_lookup_req, e_req);
      chk("key", of_lookup_data, e_key);
      chk("res_valid", res_valid, e_vld);
      if (e_vld) begin
        chk("res_err", res_err, e_err);
        chk("res_port", res_port, e_port);
      end
      chk("pkt_cnt", pkt_cnt, e_pkt);
      chk("drop_cnt", drop_cnt, e_drop);
      chk("runt_cnt", runt_cnt, e_runt);
      chk("tmo_cnt", tmo_cnt, e_tmo);
    end
    while (lq_rd < lq.size()) begin
      chk(lq[lq_rd].nm, lq[lq_rd].a, lq[lq_rd].e);
      lq_rd++;
    end
  end

  // ---------------- monitor ----------------
  int           n_req = 0, n_res = 0;
  int           req_cyc = 0, res_cyc = 0;
  logic [115:0] req_key = '0;
  logic         res_e = 0;
  logic [3:0]   res_p = 0;

  always @(negedge sys_clk) begin
    if (of_lookup_req === 1'b1) begin
      n_req <= n_req + 1; req_cyc <= cyc;
      req_key <= of_lookup_data;
    end
    if (res_valid === 1'b1) begin
      n_res <= n_res + 1; res_cyc <= cyc;
      res_e <= res_err; res_p <= res_port;
    end
  end

  // ---------------- driver ----------------
  logic [8:0] sq[$];
  int         p_gap = 0;
  bit         resp_en = 1, resp_rand = 0, force_ack = 0;
  int         resp_delay = 1, ack_cd = 0;
  logic       resp_err = 0;
  logic [3:0] resp_port = 0;
  int         d_idx = 0, t13 = 0;

  task automatic tick();
    logic rden, fire;
    logic [8:0] item;
    @(posedge sys_clk);
    #1;
    rden = sys_rst_n && !rx_empty;
    fire = 0;
    if (ack_cd > 0) begin
      ack_cd--;
      if (ack_cd == 0) fire = 1;
    end
    if (force_ack) fire = 1;
    force_ack = 0;
    if (resp_rand && $urandom_range(0, 39) == 0) fire = 1;
    if (resp_en && of_lookup_req === 1'b1)
      ack_cd = resp_rand ? int'($urandom_range(1, TMO + 3))
                         : resp_delay;
    of_lookup_ack = fire;
    if (fire && !resp_rand) begin
      of_lookup_err = resp_err;
      of_lookup_fwd_port = resp_port;
    end else begin
      of_lookup_err = ($urandom_range(0, 3) == 0);
      of_lookup_fwd_port = 4'($urandom);
    end
    rx_empty = (p_gap > 0) && ($urandom_range(0, 99) < p_gap);
    if (rden && sq.size() > 0) begin
      item = sq.pop_front();
      if (item[8]) begin
        if (d_idx == 13) t13 = cyc;
        d_idx++;
      end else d_idx = 0;
      rx_dout = item;
    end else if (rden) begin
      rx_dout = 9'h000;
      d_idx = 0;
    end else begin
      rx_dout = 9'($urandom);
    end
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic push_frame(logic [47:0] d, logic [47:0] s,
                            logic [15:0] t, int len);
    logic [111:0] h;
    logic [7:0]   b;
    h = {d, s, t};
    for (int i = 0; i < len; i++) begin
      b = (i < 14) ? h[111-8*i -: 8] : 8'($urandom);
      sq.push_back({1'b1, b});
    end
    sq.push_back(9'h000);
  endtask

  localparam logic [115:0] K1 =
    116'h2_010203040506_0A0B0C0D0E0F_0800;
  localparam logic [115:0] K4 =
    116'h2_DEADBEEF0001_112233445566_86DD;

  initial begin
    int r, g;
    sys_rst_n = 0; rx_empty = 1; rx_dout = 0;
    of_lookup_ack = 0; of_lookup_err = 0;
    of_lookup_fwd_port = 0;
    @(posedge sys_clk); #1;
    chk_on = 1;
    run(2);
    lit("rst_rd_en", rx_rd_en, 0);
    lit("rst_key", of_lookup_data, 0);
    lit("rst_pkt", pkt_cnt, 0);
    lit("rst_res", res_valid, 0);
    sys_rst_n = 1;
    run(3);

    // basic frame, single-cycle ack
    resp_delay = 1; resp_err = 0; resp_port = 3;
    r = n_res;
    push_frame(48'h010203040506, 48'h0A0B0C0D0E0F,
               16'h0800, 60);
    run(80);
    lit("t1_nres", n_res - r, 1);
    lit("t1_req_lat", req_cyc - t13, 1);
    lit("t1_res_lat", res_cyc - t13, 3);
    lit("t1_key", req_key, K1);
    lit("t1_model_key", e_key, K1);
    lit("t1_err", res_e, 0);
    lit("t1_port", res_p, 3);
    lit("t1_pkt", pkt_cnt, 1);

    // timeout, then a late ack is ignored
    resp_en = 0;
    push_frame(48'h010203040506, 48'h0A0B0C0D0E0F,
               16'h0800, 60);
    run(80);
    lit("t2_tmo_lat", res_cyc - req_cyc, 17);
    lit("t2_err", res_e, 1);
    lit("t2_port", res_p, 0);
    lit("t2_tmo", tmo_cnt, 1);
    r = n_res;
    force_ack = 1;
    run(5);
    lit("t2_late_ack", n_res - r, 0);
    resp_en = 1;

    // lookup error hides the port
    resp_delay = 3; resp_err = 1; resp_port = 5;
    push_frame(48'hAABBCCDDEEFF, 48'h001122334455,
               16'h0806, 20);
    run(40);
    lit("t3_err", res_e, 1);
    lit("t3_port", res_p, 0);

    // second key arrives while first is outstanding
    resp_delay = 15; resp_err = 0; resp_port = 7;
    r = n_res;
    push_frame(48'hDEADBEEF0001, 48'h112233445566,
               16'h86DD, 14);
    push_frame(48'hCAFEF00D0002, 48'h778899AABBCC,
               16'h0800, 14);
    run(60);
    lit("t4_drop", drop_cnt, 1);
    lit("t4_nres", n_res - r, 1);
    lit("t4_key", of_lookup_data, K4);
    lit("t4_port", res_p, 7);

    // runt then a good frame
    resp_delay = 1;
    r = n_req;
    push_frame(48'h111111111111, 48'h222222222222,
               16'h3333, 10);
    run(20);
    lit("t5_runt", runt_cnt, 1);
    lit("t5_noreq", n_req - r, 0);
    push_frame(48'h444444444444, 48'h555555555555,
               16'h6666, 16);
    run(30);
    lit("t5_req", n_req - r, 1);
    lit("t5_pkt", pkt_cnt, 5);

    // reset while waiting, ack lands inside reset
    resp_en = 0;
    r = n_req;
    push_frame(48'h0A0A0A0A0A0A, 48'h0B0B0B0B0B0B,
               16'h0C0C, 14);
    run(18);
    lit("t6_req_seen", n_req - r, 1);
    sq.delete(); d_idx = 0; ack_cd = 0;
    sys_rst_n = 0;
    force_ack = 1;
    tick();
    lit("t6_rst_req", of_lookup_req, 0);
    lit("t6_rst_res", res_valid, 0);
    lit("t6_rst_key", of_lookup_data, 0);
    lit("t6_rst_pkt", pkt_cnt, 0);
    lit("t6_rst_rd", rx_rd_en, 0);
    run(2);
    sys_rst_n = 1;
    resp_en = 1; resp_delay = 1;
    r = n_res;
    run(20);
    lit("t6_no_res", n_res - r, 0);
    push_frame(48'h0D0D0D0D0D0D, 48'h0E0E0E0E0E0E,
               16'h0F0F, 14);
    run(30);
    lit("t6_pkt", pkt_cnt, 1);
    lit("t6_res", n_res - r, 1);

    // random traffic, gaps and ack timing
    resp_rand = 1; p_gap = 30;
    for (int i = 0; i < 40; i++) begin
      push_frame(48'({$urandom, $urandom}),
                 48'({$urandom, $urandom}),
                 16'($urandom),
                 int'($urandom_range(0, 24)));
      repeat ($urandom_range(0, 20)) sq.push_back(9'h000);
    end
    g = 0;
    while (sq.size() > 0 && g < 20000) begin
      tick();
      g++;
    end
    lit("rand_drain", sq.size(), 0);
    resp_rand = 0; p_gap = 0;
    run(60);

    repeat (3) @(negedge sys_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flowkey_extract.md
Name: flowkey_extract

Overview:
Upstream neighbour of the flow lookup stage. Reads the 9-bit per-port RX FIFO byte stream and captures the 14-byte Ethernet header of each frame. It builds the 116-bit flow key {in_port, eth_dst, eth_src, eth_type}, issues one lookup request per frame, and returns the forwarding result (or an error/timeout) to the switch fabric control. It parses only; the frame payload path is separate and never back-pressured by this block.

Parameters:
PORT_NUM, 4'h0, ingress port number placed in key bits [115:112]
TIMEOUT, 8'd16, cycles to wait for of_lookup_ack before declaring error (must be >= 2)
CNT_W, 16, width of the statistics counters

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset, asynchronous assert, active-low
rx_dout  in  9  FIFO data; bit8=1 means in-frame byte, bit8=0 means inter-frame/end marker; [7:0] byte
rx_empty  in  1  FIFO empty
rx_rd_en  out  1  FIFO read enable, registered
of_lookup_req  out  1  lookup request, single-cycle pulse
of_lookup_data  out  116  flow key, stable from req until ack/timeout
of_lookup_ack  in  1  lookup done pulse
of_lookup_err  in  1  lookup error, qualified by ack
of_lookup_fwd_port  in  4  forwarding port, qualified by ack
res_valid  out  1  result pulse, one per issued request
res_err  out  1  1 = of_lookup_err or timeout, qualified by res_valid
res_port  out  4  forwarding port (0 when res_err), qualified by res_valid
pkt_cnt  out  CNT_W  keys issued, saturating
drop_cnt  out  CNT_W  keys discarded because a lookup was outstanding, saturating
runt_cnt  out  CNT_W  frames ended before 14 bytes, saturating
tmo_cnt  out  CNT_W  lookups that timed out, saturating

Behaviour:
- Reset (async, sys_rst_n=0): all outputs 0, FSM=IDLE, byte counter 0, key register 0. Reset mid-lookup abandons the lookup silently. No counter increment.
- rx_rd_en <= ~rx_empty every cycle. rx_dout is valid in every cycle where rx_rd_en=1; accepted byte = rx_rd_en & rx_dout[8].
- Byte counter bcnt[3:0]: +1 on each accepted byte, saturates at 14. Cleared when rx_rd_en=1 and rx_dout[8]=0 (end of frame).
- End of frame with 0 < bcnt < 14: runt_cnt+1. No key is built.
- Key capture by byte index: 0-5 -> eth_dst[47:0], MSB first; 6-11 -> eth_src; 12-13 -> eth_type.
- Key layout: [115:112]=PORT_NUM, [111:64]=eth_dst, [63:16]=eth_src, [15:0]=eth_type.
- key_done: asserted in the cycle byte index 13 is accepted.
  - FSM in IDLE: next cycle load of_lookup_data with the key, pulse of_lookup_req for 1 cycle, increment pkt_cnt, go to WAIT.
  - FSM not in IDLE: discard the key, drop_cnt+1, of_lookup_data unchanged.
- Staging: the header shift register feeds of_lookup_data only on issue. A following frame's bytes never corrupt an outstanding key.
- FSM states:
  - IDLE: waiting for key_done.
  - WAIT: of_lookup_req=0, timer counts from 1.
    - of_lookup_ack=1: next cycle res_valid=1, res_err=of_lookup_err, res_port = err ? 0 : of_lookup_fwd_port; go to IDLE.
    - Else timer==TIMEOUT: next cycle res_valid=1, res_err=1, res_port=0, tmo_cnt+1; go to IDLE.
    - Ack and timer==TIMEOUT in the same cycle: ack wins, no timeout counted.
- Ack in IDLE (spurious/late): ignored, no res_valid.
- key_done in the same cycle the FSM leaves WAIT: FSM not yet IDLE, so the key is dropped (drop_cnt+1).
- Latency: byte 13 accepted at cycle t -> req at t+1. With single-cycle lookup ack at t+2 -> res_valid at t+3.
- Counters stop at all-ones, no wrap.
- Frames longer than 14 bytes: extra bytes ignored until the end marker.
- A frame with no end marker before a new frame: not possible (bit8 framing). bcnt saturation prevents false re-trigger.

Test Plan:
- Frame dst=01:02:03:04:05:06, src=0A:0B:0C:0D:0E:0F, type=0x0800, PORT_NUM=2, 60 bytes; ack at t+2 with fwd_port=3, err=0 -> req pulse 1 cycle at t+1, of_lookup_data=0x2_010203040506_0A0B0C0D0E0F_0800; res_valid at t+3, res_port=3, res_err=0; pkt_cnt=1.
- Same frame, ack never returned, TIMEOUT=16 -> res_valid 17 cycles after req, res_err=1, res_port=0, tmo_cnt=1; then a further ack in IDLE -> no res_valid.
- Ack with err=1, fwd_port=5 -> res_err=1, res_port=0.
- Two back-to-back 14-byte frames, ack delayed 20 cycles with TIMEOUT=32 -> second key dropped, drop_cnt=1, of_lookup_data still holds first key; one res_valid only.
- 10-byte frame followed by end marker -> runt_cnt=1, no req; next valid frame -> normal req.
- Assert sys_rst_n=0 in WAIT, ack arrives during reset -> outputs 0, no res_valid; after release, a new frame gives pkt_cnt=1.
